// File: rtl/alu_ctrl_decode_stage_if.sv
// Decode-stage bus: fetch-side instr handshake, flush,
// execute-side decoded fields handshake.
interface alu_ctrl_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        alu_src_imm;
  logic        reg_write;
  logic        illegal;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, alu_ctrl,
    input  rs1, rs2, rd, imm,
    input  alu_src_imm, reg_write, illegal
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, alu_ctrl,
    output rs1, rs2, rd, imm,
    output alu_src_imm, reg_write, illegal
  );
endinterface

// File: rtl/alu_ctrl_decode_stage.sv
// RV32I OP/OP-IMM/LUI -> ALU control decode, one-entry
// registered stage. Ports: clk, reset (async high), bus (slave).
module alu_ctrl_decode_stage #(
  parameter int         XLEN       = 32,
  parameter logic [3:0] RESET_CTRL = 4'b0000
) (
  input  logic clk,
  input  logic reset,
  alu_ctrl_decode_stage_if.slave bus
);

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b1000;
  localparam logic [3:0] SRA = 4'b1101;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            src_imm;
    logic            reg_write;
    logic            illegal;
  } dec_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] shamt;
  logic       is_op;
  logic       is_opi;
  logic       is_lui;
  logic       take;
  logic       valid_q;
  dec_t       d;
  dec_t       q;

  assign opc    = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  assign shamt  = bus.instr[24:20];
  assign is_op  = (opc == 7'b0110011);
  assign is_opi = (opc == 7'b0010011);
  assign is_lui = (opc == 7'b0110111);

  always_comb begin
    d         = '0;
    d.ctrl    = ADD;
    d.rs1     = bus.instr[19:15];
    d.rs2     = bus.instr[24:20];
    d.rd      = bus.instr[11:7];
    unique case (1'b1)
      is_op: begin
        if (f7 == F7_BASE)
          d.ctrl = {1'b0, f3};
        else if (f7 == F7_ALT && f3 == 3'b000)
          d.ctrl = SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)
          d.ctrl = SRA;
        else
          d.illegal = 1'b1;
      end
      is_opi: begin
        // ADDI keeps funct3 map only; imm bit 30 never selects SUB
        d.src_imm = 1'b1;
        d.ctrl    = {1'b0, f3};
        d.imm     = {{20{bus.instr[31]}}, bus.instr[31:20]};
        if (f3 == 3'b001) begin
          d.imm     = {27'b0, shamt};
          d.illegal = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          d.imm = {27'b0, shamt};
          if (f7 == F7_ALT)
            d.ctrl = SRA;
          else
            d.illegal = (f7 != F7_BASE);
        end
      end
      is_lui: begin
        d.src_imm = 1'b1;
        d.rs1     = 5'd0;
        d.imm     = {bus.instr[31:12], 12'b0};
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.ctrl    = ADD;
      d.src_imm = 1'b0;
      d.imm     = '0;
    end
    d.reg_write = !d.illegal && (d.rd != 5'd0);
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign take = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (take) begin
      valid_q <= 1'b1;
      q       <= d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.alu_ctrl    = valid_q ? q.ctrl : RESET_CTRL;
  assign bus.rs1         = q.rs1;
  assign bus.rs2         = q.rs2;
  assign bus.rd          = q.rd;
  assign bus.imm         = q.imm;
  assign bus.alu_src_imm = q.src_imm;
  assign bus.reg_write   = q.reg_write;
  assign bus.illegal     = q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Scoreboard bench for alu_ctrl_decode_stage: table stimulus,
// backpressure, flush and async reset.
module tb_alu_ctrl_decode_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  alu_ctrl_decode_stage_if bus ();

  alu_ctrl_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [53:0] sb[$];

  function automatic logic [53:0] pk(
    input logic [3:0] c, input logic [4:0] a,
    input logic [4:0] b, input logic [4:0] r,
    input logic [31:0] im, input logic s,
    input logic w, input logic il);
    return {c, a, b, r, im, s, w, il};
  endfunction

  function automatic logic [53:0] obs();
    return pk(bus.alu_ctrl, bus.rs1, bus.rs2, bus.rd,
              bus.imm, bus.alu_src_imm, bus.reg_write,
              bus.illegal);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0)
        chk("unexpected_out", 1, 0);
      else
        chk("decode", {10'b0, obs()}, {10'b0, sb.pop_front()});
    end
  end

  task automatic send(input logic [31:0] i,
                      input logic [53:0] e);
    int n = 0;
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.instr = i;
    while (!acc && n < 50) begin
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) sb.push_back(e);
      n++;
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  logic [31:0] vi[12];
  logic [53:0] ve[12];
  logic [53:0] frz;
  int t0;

  initial begin
    vi[0]  = 32'h002081B3;
    ve[0]  = pk(4'h0, 1, 2, 3, 0, 0, 1, 0);
    vi[1]  = 32'h402081B3;
    ve[1]  = pk(4'h8, 1, 2, 3, 0, 0, 1, 0);
    vi[2]  = 32'hFFF00093;
    ve[2]  = pk(4'h0, 0, 31, 1, 32'hFFFFFFFF, 1, 1, 0);
    vi[3]  = 32'h40335293;
    ve[3]  = pk(4'hD, 6, 3, 5, 3, 1, 1, 0);
    vi[4]  = 32'h123453B7;
    ve[4]  = pk(4'h0, 0, 3, 7, 32'h12345000, 1, 1, 0);
    vi[5]  = 32'h00000000;
    ve[5]  = pk(4'h0, 0, 0, 0, 0, 0, 0, 1);
    vi[6]  = 32'h022081B3;
    ve[6]  = pk(4'h0, 1, 2, 3, 0, 0, 0, 1);
    vi[7]  = 32'h0020C1B3;
    ve[7]  = pk(4'h4, 1, 2, 3, 0, 0, 1, 0);
    vi[8]  = 32'h00409093;
    ve[8]  = pk(4'h1, 1, 4, 1, 4, 1, 1, 0);
    vi[9]  = 32'h02409093;
    ve[9]  = pk(4'h0, 1, 4, 1, 0, 0, 0, 1);
    vi[10] = 32'h00513013;
    ve[10] = pk(4'h3, 2, 5, 0, 5, 1, 0, 0);
    vi[11] = 32'h8002F213;
    ve[11] = pk(4'h7, 5, 0, 4, 32'hFFFFF800, 1, 1, 0);

    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {63'b0, bus.out_valid}, 0);
    chk("rst_in_ready", {63'b0, bus.in_ready}, 1);
    chk("rst_alu_ctrl", {60'b0, bus.alu_ctrl}, 0);
    chk("rst_fields", {10'b0, obs()}, 0);
    @(negedge clk);
    reset = 1'b0;

    // back-to-back stream, one accepted per cycle
    t0 = cyc;
    for (int k = 0; k < 12; k++) send(vi[k], ve[k]);
    chk("throughput", 64'(cyc - t0), 12);
    @(posedge clk); #1;
    chk("drain_valid", {63'b0, bus.out_valid}, 0);
    chk("idle_alu_ctrl", {60'b0, bus.alu_ctrl}, 0);

    // backpressure: hold 3 cycles with a pending input
    bus.out_ready = 1'b0;
    send(vi[1], ve[1]);
    fork
      send(vi[3], ve[3]);
      begin
        @(negedge clk);
        frz = obs();
        for (int k = 0; k < 3; k++) begin
          chk("bp_in_ready", {63'b0, bus.in_ready}, 0);
          chk("bp_frozen", {10'b0, obs()}, {10'b0, frz});
          chk("bp_valid", {63'b0, bus.out_valid}, 1);
          if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    send(vi[4], ve[4]);
    @(posedge clk); #1;

    // flush with a held entry and a new incoming one
    bus.out_ready = 1'b0;
    send(vi[0], ve[0]);
    bus.in_valid = 1'b1;
    bus.instr = vi[7];
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", {63'b0, bus.out_valid}, 0);
    chk("flush_ctrl", {60'b0, bus.alu_ctrl}, 0);
    void'(sb.pop_front());
    bus.out_ready = 1'b1;
    send(vi[2], ve[2]);
    @(posedge clk); #1;

    // async reset with a held entry, no clock edge
    bus.out_ready = 1'b0;
    send(vi[1], ve[1]);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {63'b0, bus.out_valid}, 0);
    chk("async_rst_fields", {10'b0, obs()}, 0);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    send(vi[8], ve[8]);
    send(vi[11], ve[11]);

    for (int k = 0; k < 20 && sb.size() != 0; k++)
      @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
